// File: rtl/cache_read_fill.sv
// Load path of the write-through L1 D-cache: tag/valid lookup, 4-beat line refill on miss,
// and sign/zero extraction of the requested datum.
module cache_read_fill #(
   parameter int TAG_BITS   = 22,
   parameter int INDEX_BITS = 6,
   parameter int LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_req,
   input  logic                  core_write,
   input  logic [31:0]           core_addr,
   input  logic [2:0]            core_type,
   output logic [31:0]           core_out,
   output logic                  core_wait,
   output logic                  D_req,
   output logic                  D_write,
   output logic [31:0]           D_addr,
   output logic [2:0]            D_type,
   input  logic [31:0]           D_out,
   input  logic                  D_wait,
   output logic [INDEX_BITS-1:0] index,
   output logic [TAG_BITS-1:0]   TA_in,
   output logic                  TA_write,
   output logic                  TA_read,
   input  logic [TAG_BITS-1:0]   TA_out,
   output logic [127:0]          DA_in,
   output logic [15:0]           DA_write,
   output logic                  DA_read,
   input  logic [127:0]          DA_out,
   output logic                  valid_read,
   input  logic                  valid_data_from_register,
   output logic                  valid_write,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOOKUP  = 3'd1;
   localparam logic [2:0] CHECK   = 3'd2;
   localparam logic [2:0] REFILL  = 3'd3;
   localparam logic [2:0] FILL    = 3'd4;
   localparam logic [2:0] RESPOND = 3'd5;

   localparam logic [2:0] CACHE_BYTE    = 3'b000;
   localparam logic [2:0] CACHE_HWORD   = 3'b001;
   localparam logic [2:0] CACHE_WORD    = 3'b010;
   localparam logic [2:0] CACHE_BYTE_U  = 3'b100;
   localparam logic [2:0] CACHE_HWORD_U = 3'b101;

   logic [2:0]            state, next;
   logic [31:0]           addr_q;
   logic [2:0]            type_q;
   logic [127:0]          line_q;
   logic [1:0]            beat_q;
   logic                  valid_q;
   logic [TAG_BITS-1:0]   tag_q;
   logic [INDEX_BITS-1:0] idx_q;
   logic                  hit;
   logic [31:0]           da_word, buf_word;

   assign tag_q    = addr_q[31 -: TAG_BITS];
   assign idx_q    = addr_q[4 +: INDEX_BITS];
   assign hit      = valid_q && (TA_out == tag_q);
   assign da_word  = DA_out[{addr_q[3:2], 5'b00000} +: 32];
   assign buf_word = line_q[{addr_q[3:2], 5'b00000} +: 32];
   assign D_write  = 1'b0;
   assign D_type   = rst ? CACHE_WORD : 3'b000;

   // Halfword lane ignores addr[0]; WORD ignores both offset bits.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] t);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (t)
         CACHE_BYTE:    extract = {{24{b[7]}}, b};
         CACHE_HWORD:   extract = {{16{h[15]}}, h};
         CACHE_WORD:    extract = w;
         CACHE_BYTE_U:  extract = {24'd0, b};
         CACHE_HWORD_U: extract = {16'd0, h};
         default:       extract = 32'd0;
      endcase
   endfunction

   always_comb begin
      next        = state;
      core_wait   = 1'b0;
      D_req       = 1'b0;
      D_addr      = 32'd0;
      index       = '0;
      TA_in       = '0;
      TA_write    = 1'b0;
      TA_read     = 1'b0;
      DA_in       = 128'd0;
      DA_write    = 16'hffff;
      DA_read     = 1'b0;
      valid_read  = 1'b0;
      valid_write = 1'b0;
      case (state)
         IDLE: if (rst && core_req && !core_write) begin
            core_wait = 1'b1;
            next      = LOOKUP;
         end
         LOOKUP, CHECK: begin
            core_wait  = 1'b1;
            index      = idx_q;
            TA_read    = 1'b1;
            DA_read    = 1'b1;
            valid_read = 1'b1;
            if (state == LOOKUP) next = CHECK;
            else                 next = hit ? RESPOND : REFILL;
         end
         REFILL: begin
            core_wait = 1'b1;
            D_req     = 1'b1;
            D_addr    = {tag_q, idx_q, beat_q, 2'b00};
            if (!D_wait && beat_q == 2'(LINE_WORDS - 1)) next = FILL;
         end
         FILL: begin
            core_wait   = 1'b1;
            index       = idx_q;
            TA_in       = tag_q;
            TA_write    = 1'b1;
            DA_in       = line_q;
            DA_write    = 16'h0000;
            valid_write = 1'b1;
            next        = RESPOND;
         end
         RESPOND: next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr_q     <= 32'd0;
         type_q     <= 3'd0;
         line_q     <= 128'd0;
         beat_q     <= 2'd0;
         valid_q    <= 1'b0;
         core_out   <= 32'd0;
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         state <= next;
         case (state)
            IDLE: if (core_req && !core_write) begin
               addr_q <= core_addr;
               type_q <= core_type;
            end
            LOOKUP: valid_q <= valid_data_from_register;
            CHECK: if (hit) begin
               core_out  <= extract(da_word, addr_q[1:0], type_q);
               hit_count <= hit_count + 32'd1;
            end else begin
               miss_count <= miss_count + 32'd1;
               beat_q     <= 2'd0;
            end
            REFILL: if (!D_wait) begin
               line_q[{beat_q, 5'b00000} +: 32] <= D_out;
               beat_q <= beat_q + 2'd1;
            end
            FILL: core_out <= extract(buf_word, addr_q[1:0], type_q);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_read_fill.sv
// Bench for cache_read_fill: directed test-plan sequences, an extraction vector table and
// randomized loads checked against a set/tag cache model over a flat memory image.
module tb_cache_read_fill;

   localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

   logic         clk = 1'b0, rst = 1'b0;
   logic         core_req = 1'b0, core_write = 1'b0;
   logic [31:0]  core_addr = 32'd0;
   logic [2:0]   core_type = 3'd0;
   logic [31:0]  core_out;
   logic         core_wait;
   logic         D_req, D_write;
   logic [31:0]  D_addr;
   logic [2:0]   D_type;
   logic [31:0]  D_out = 32'd0;
   logic         D_wait = 1'b0;
   logic [5:0]   index;
   logic [21:0]  TA_in, TA_out;
   logic         TA_write, TA_read;
   logic [127:0] DA_in, DA_out;
   logic [15:0]  DA_write;
   logic         DA_read, valid_read, valid_data_from_register, valid_write;
   logic [31:0]  hit_count, miss_count;

   always #5 clk = ~clk;

   cache_read_fill dut (
      .clk(clk), .rst(rst), .core_req(core_req), .core_write(core_write),
      .core_addr(core_addr), .core_type(core_type), .core_out(core_out), .core_wait(core_wait),
      .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_type(D_type), .D_out(D_out),
      .D_wait(D_wait), .index(index), .TA_in(TA_in), .TA_write(TA_write), .TA_read(TA_read),
      .TA_out(TA_out), .DA_in(DA_in), .DA_write(DA_write), .DA_read(DA_read), .DA_out(DA_out),
      .valid_read(valid_read), .valid_data_from_register(valid_data_from_register),
      .valid_write(valid_write), .hit_count(hit_count), .miss_count(miss_count)
   );

   // Shared arrays the block reads and fills
   logic [21:0]  tag_arr  [64] = '{default: 22'h15555};
   logic [127:0] data_arr [64] = '{default: {4{32'hDEAD_BEEF}}};
   logic         valid_arr[64] = '{default: 1'b0};
   assign TA_out = tag_arr[index];
   assign DA_out = data_arr[index];
   assign valid_data_from_register = valid_arr[index];
   always @(posedge clk) begin
      if (TA_write) tag_arr[index] <= TA_in;
      if (DA_write == 16'h0000) data_arr[index] <= DA_in;
      if (valid_write) valid_arr[index] <= 1'b1;
   end

   logic [31:0] mem [logic [31:0]];
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0] ^ 16'hA5C3, a[31:16] + a[15:0] + 16'h8181};
   endfunction

   // Memory responder plus bus monitor
   bit          rand_wait = 0;
   logic [31:0] stall_addr = 32'hFFFF_FFFF;
   int          stall_len = 0, st_cnt = 0;
   int          wait_cyc = 0, hold_chk = 0, hold_err = 0, fill_cnt = 0;
   bit          prev_wait = 0;
   logic [31:0] held_addr = 32'd0;
   logic [31:0] beat_log[$];
   logic [21:0] fill_tag;
   logic [5:0]  fill_idx;
   logic [127:0] fill_data;
   logic [15:0] fill_dawr;
   always @(negedge clk) begin
      if (prev_wait) begin
         hold_chk++;
         if (!(D_req && D_addr == held_addr)) hold_err++;
      end
      D_out = mem_rd(D_addr);
      if (D_req && D_addr == stall_addr && st_cnt < stall_len) begin
         D_wait = 1'b1;
         st_cnt++;
      end else begin
         if (!(D_req && D_addr == stall_addr)) st_cnt = 0;
         D_wait = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      prev_wait = D_req && D_wait;
      held_addr = D_addr;
      if (D_req && !D_wait) beat_log.push_back(D_addr);
      if (D_req && D_wait) wait_cyc++;
      if (TA_write) begin
         fill_cnt++;
         fill_tag = TA_in; fill_idx = index; fill_data = DA_in; fill_dawr = DA_write;
      end
   end

   int total = 0, bad = 0;
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: which line each set holds, and the load semantics from memory
   bit          m_valid[64];
   logic [21:0] m_tag[64];
   int          m_hits = 0, m_miss = 0;

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
      longint w, b, h;
      w = longint'(mem_rd({a[31:2], 2'b00}));
      b = (w >> (8 * a[1:0])) & 255;
      h = (w >> (16 * a[1])) & 65535;
      case (t)
         T_B:  return 32'(b >= 128 ? b - 256 : b);
         T_H:  return 32'(h >= 32768 ? h - 65536 : h);
         T_W:  return 32'(w);
         T_BU: return 32'(b);
         T_HU: return 32'(h);
         default: return 32'd0;
      endcase
   endfunction

   task automatic do_load(input logic [31:0] a, input logic [2:0] t,
                          output logic [31:0] data, output int lat, output bit to);
      @(negedge clk);
      core_req = 1'b1; core_write = 1'b0; core_addr = a; core_type = t;
      #1 chk("wait_on_request", core_wait, 1'b1);
      @(negedge clk);
      lat = 1;
      while (core_wait === 1'b1 && lat < 200) begin
         core_req = 1'($urandom); core_write = 1'($urandom);
         core_addr = $urandom; core_type = 3'($urandom);
         @(negedge clk);
         lat++;
      end
      core_req = 1'b0;
      to = (core_wait !== 1'b0);
      data = core_out;
   endtask

   task automatic load_check(input logic [31:0] a, input logic [2:0] t, output logic [31:0] got);
      bit hit, to;
      int lat, w0, b0;
      logic [31:0] exp;
      hit = m_valid[a[9:4]] && m_tag[a[9:4]] == a[31:10];
      exp = ref_load(a, t);
      w0 = wait_cyc;
      b0 = beat_log.size();
      do_load(a, t, got, lat, to);
      if (hit) m_hits++;
      else begin
         m_miss++;
         m_valid[a[9:4]] = 1'b1;
         m_tag[a[9:4]] = a[31:10];
      end
      chk("no_timeout", to, 1'b0);
      chk("core_out", got, exp);
      chk("latency", lat, hit ? 3 : 8 + (wait_cyc - w0));
      chk("beat_count", beat_log.size() - b0, hit ? 0 : 4);
      if (!hit && beat_log.size() - b0 == 4)
         for (int k = 0; k < 4; k++)
            chk("beat_addr", beat_log[b0 + k], {a[31:4], 2'(k), 2'b00});
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_miss);
   endtask

   typedef struct { logic [31:0] a; logic [2:0] t; logic [31:0] e; } vec_t;
   vec_t tbl[12];

   initial begin
      logic [31:0] got;
      int n, f0, w0, hc0, he0, b0;
      tbl[0]  = '{32'h409, T_B,    32'h0000_007F};
      tbl[1]  = '{32'h40B, T_B,    32'hFFFF_FF80};
      tbl[2]  = '{32'h40A, T_HU,   32'h0000_80FF};
      tbl[3]  = '{32'h40A, T_H,    32'hFFFF_80FF};
      tbl[4]  = '{32'h408, T_W,    32'h80FF_7F01};
      tbl[5]  = '{32'h409, T_BU,   32'h0000_007F};
      tbl[6]  = '{32'h40B, T_BU,   32'h0000_0080};
      tbl[7]  = '{32'h408, T_HU,   32'h0000_7F01};
      tbl[8]  = '{32'h409, T_H,    32'h0000_7F01};
      tbl[9]  = '{32'h408, 3'b011, 32'h0000_0000};
      tbl[10] = '{32'h40F, T_W,    32'h0000_0044};
      tbl[11] = '{32'h400, T_B,    32'h0000_0011};
      mem[32'h400] = 32'h11; mem[32'h404] = 32'h22; mem[32'h408] = 32'h33; mem[32'h40C] = 32'h44;

      // Reset values
      repeat (2) @(negedge clk);
      core_req = 1'b1;
      #1;
      chk("rst_core_wait", core_wait, 1'b0);
      chk("rst_core_out", core_out, 32'd0);
      chk("rst_D_req", D_req, 1'b0);
      chk("rst_D_addr", D_addr, 32'd0);
      chk("rst_DA_write", DA_write, 16'hffff);
      chk("rst_TA_write", TA_write, 1'b0);
      chk("rst_counts", {hit_count, miss_count}, 64'd0);
      core_req = 1'b0;
      @(negedge clk) rst = 1'b1;

      // Reset asserted during beat 1 of a cold miss
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h404; core_type = T_W;
      @(negedge clk) core_req = 1'b0;
      n = 0;
      while (!(D_req && D_addr == 32'h404) && n < 50) begin @(negedge clk); n++; end
      chk("beat1_addr", D_addr, 32'h404);
      #2 rst = 1'b0;
      #1;
      chk("midrst_D_req", D_req, 1'b0);
      chk("midrst_core_wait", core_wait, 1'b0);
      chk("midrst_DA_write", DA_write, 16'hffff);
      chk("midrst_miss_count", miss_count, 32'd0);
      @(negedge clk);
      chk("midrst_no_fill", fill_cnt, 0);
      rst = 1'b1;

      // Cold miss on 0x404 (valid never set by the aborted load)
      f0 = fill_cnt;
      load_check(32'h404, T_W, got);
      chk("tp1_core_out", got, 32'h22);
      chk("tp1_fill_seen", fill_cnt - f0, 1);
      chk("tp1_fill_tag", fill_tag, 22'h1);
      chk("tp1_fill_idx", fill_idx, 6'd0);
      chk("tp1_fill_data", fill_data, {32'h44, 32'h33, 32'h22, 32'h11});
      chk("tp1_fill_dawr", fill_dawr, 16'h0000);
      chk("tp1_miss_count", miss_count, 32'd1);

      // Same load hits
      load_check(32'h404, T_W, got);
      chk("tp2_core_out", got, 32'h22);
      chk("tp2_hit_count", hit_count, 32'd1);

      // Store request in IDLE is ignored
      @(negedge clk);
      core_req = 1'b1; core_write = 1'b1; core_addr = 32'h404; core_type = T_W;
      #1 chk("store_wait", core_wait, 1'b0);
      @(negedge clk);
      chk("store_stays_idle", {core_wait, D_req, TA_read}, 3'b000);
      core_req = 1'b0; core_write = 1'b0;

      // Same index, new tag: line replaced
      load_check(32'h804, T_W, got);
      chk("tp5_fill_tag", fill_tag, 22'h2);
      chk("tp5_tag_array", tag_arr[0], 22'h2);

      // Extraction table; first vector refills 0x400 with a 5-cycle stall on beat 2
      mem[32'h408] = 32'h80FF_7F01;
      stall_addr = 32'h408;
      stall_len = 5;
      w0 = wait_cyc; hc0 = hold_chk; he0 = hold_err; b0 = beat_log.size();
      for (int i = 0; i < 12; i++) begin
         load_check(tbl[i].a, tbl[i].t, got);
         chk($sformatf("tbl%0d", i), got, tbl[i].e);
         if (i == 0) begin
            chk("stall_cycles", wait_cyc - w0, 5);
            chk("stall_hold_checks", hold_chk - hc0, 5);
            chk("stall_hold_errors", hold_err - he0, 0);
            chk("stall_beat2", beat_log[b0 + 2], 32'h408);
         end
      end
      stall_len = 0;

      // Randomized loads over a few sets and aliasing tags with random memory stalls
      rand_wait = 1;
      for (int i = 0; i < 60; i++) begin
         logic [21:0] tg;
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0: tg = 22'h0; 1: tg = 22'h1; 2: tg = 22'h2; default: tg = 22'h2AAAAA;
         endcase
         a = {tg, 6'($urandom_range(0, 3)), 4'($urandom)};
         if ($urandom_range(0, 4) == 0) mem[{a[31:2], 2'b00}] = $urandom;
         // keep memory and cached copies coherent: only rewrite lines not cached
         if (m_valid[a[9:4]] && m_tag[a[9:4]] == a[31:10] && mem.exists({a[31:2], 2'b00}))
            mem[{a[31:2], 2'b00}] = data_arr[a[9:4]][{a[3:2], 5'b0} +: 32];
         load_check(a, 3'($urandom), got);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
